// File: rtl/conv_pkg.sv
// Shared types and constants for the byte-to-word packer.
// Lane parity helper is used only when BYTE_WORD_PACKER_PARITY_EN is defined.
package conv_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [63:0] word_t;

    localparam int BYTES_PER_WORD = 8;
    localparam int BCNT_W         = 3;

    // Bit i is the XOR of byte lane i, so lane plus bit carries even ones.
    function automatic logic [7:0] lane_parity(input word_t w);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            p[i] = ^w[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/packer_fifo.sv
// Synchronous word FIFO with a registered head-of-queue output.
// Push into an empty FIFO is visible on dout one cycle later.
module packer_fifo
    import conv_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;
    logic [WIDTH-1:0] r_dout;

    logic             w_pop;
    logic             w_push;
    logic [AW-1:0]    w_rd_nxt;
    logic [CW-1:0]    w_cnt_pop;
    logic [CW-1:0]    w_cnt_nxt;

    assign full  = (r_cnt == CW'(DEPTH));
    assign empty = !r_valid;
    assign dout  = r_dout;

    // A pop frees a slot for a push in the same cycle, even when full.
    assign w_pop     = pop && r_valid;
    assign w_push    = push && (!full || w_pop);
    assign w_rd_nxt  = w_pop ? r_rd + AW'(1) : r_rd;
    assign w_cnt_pop = w_pop ? r_cnt - CW'(1) : r_cnt;
    assign w_cnt_nxt = w_push ? w_cnt_pop + CW'(1) : w_cnt_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            r_rd    <= w_rd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != '0);
            // Head comes from the bypass only when nothing older remains.
            if (w_push && (w_cnt_pop == '0)) begin
                r_dout <= din;
            end else if (w_cnt_pop != '0) begin
                r_dout <= r_mem[w_rd_nxt];
            end
        end
    end

endmodule

// File: rtl/byte_word_packer.sv
// Collects 8 bytes into a 64-bit word and queues it in packer_fifo.
// Optional lane parity output: define BYTE_WORD_PACKER_PARITY_EN.
module byte_word_packer
    import conv_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk_out,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [7:0]  data_in,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [63:0] word_data,
    output logic        overflow,
    output logic [2:0]  byte_cnt
`ifdef BYTE_WORD_PACKER_PARITY_EN
    ,
    output logic [7:0]  word_parity
`endif
);

    word_t             r_asm;
    logic [BCNT_W-1:0] r_cnt;
    logic              r_ovf;

    logic [BCNT_W-1:0] w_lane;
    word_t             w_word;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;

    assign w_lane = MSB_FIRST ? ~r_cnt : r_cnt;
    assign w_push = valid_in && (r_cnt == BCNT_W'(BYTES_PER_WORD - 1));
    assign w_pop  = !w_empty && word_ready;

    // Completed word includes the byte arriving this cycle.
    always_comb begin
        w_word = r_asm;
        w_word[{w_lane, 3'b000} +: 8] = data_in;
    end

    always_ff @(posedge clk_out) begin
        if (rst) begin
            r_asm <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (valid_in) begin
                r_cnt <= r_cnt + BCNT_W'(1);
                r_asm <= w_push ? '0 : w_word;
            end
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign word_valid = !w_empty;
    assign overflow   = r_ovf;
    assign byte_cnt   = r_cnt;

`ifdef BYTE_WORD_PACKER_PARITY_EN
    logic [71:0] w_fifo_out;

    packer_fifo #(
        .WIDTH (72),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_out),
        .rst   (rst),
        .push  (w_push),
        .din   ({lane_parity(w_word), w_word}),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .dout  (w_fifo_out)
    );

    assign word_data   = w_fifo_out[63:0];
    assign word_parity = w_fifo_out[71:64];
`else
    packer_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_out),
        .rst   (rst),
        .push  (w_push),
        .din   (w_word),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .dout  (word_data)
    );
`endif

endmodule

// File: doc/byte_word_packer.md
BYTE_WORD_PACKER -- requirements
Module: byte_word_packer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2: output word FIFO depth in words (power of two, >=2).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = first byte of a word lands in [63:56]; 0 = first byte lands in [7:0].
REQ-003 The block SHALL have a port clk_out  input  1  single clock; all logic on posedge.
REQ-004 The block SHALL have a port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have a port valid_in  input  1  byte strobe from the 64-to-8 converter; no backpressure path exists.
REQ-006 The block SHALL have a port data_in  input  8  byte, sampled when valid_in=1.
REQ-007 The block SHALL have a port word_valid  output  1  FIFO non-empty; word_data is valid.
REQ-008 The block SHALL have a port word_ready  input  1  consumer accepts word_data on a cycle with word_valid && word_ready.
REQ-009 The block SHALL have a port word_data  output  64  head-of-FIFO word.
REQ-010 The block SHALL have a port overflow  output  1  sticky; a complete word was dropped.
REQ-011 The block SHALL have a port byte_cnt  output  3  number of bytes collected toward the current word.

Function
REQ-012 Each cycle with valid_in=1, data_in SHALL be written into the assembly register at the byte lane given by byte_cnt and MSB_FIRST, and byte_cnt SHALL increment modulo 8.
REQ-013 On the cycle the 8th byte is sampled (byte_cnt=7, valid_in=1), the completed word, including that byte, SHALL be pushed into the FIFO, and byte_cnt SHALL wrap to 0.
REQ-014 Latency SHALL be exactly one cycle: word_valid rises on the cycle after the 8th byte is sampled, provided the FIFO was empty.
REQ-015 word_data and word_valid SHALL be registered and held stable while word_valid=1 and word_ready=0.
REQ-016 A pop SHALL occur only when word_valid=1 and word_ready=1; word_ready while empty SHALL have no effect.
REQ-017 A push and a pop in the same cycle at FIFO full SHALL both succeed, with the occupancy unchanged.
REQ-018 A push at FIFO full without a simultaneous pop SHALL drop the word and set overflow; byte_cnt SHALL still wrap to 0 and the FIFO contents SHALL be unchanged.
REQ-019 A push and a pop in the same cycle at FIFO empty SHALL be treated as a push only.
REQ-020 Once set, overflow SHALL remain 1 until rst.
REQ-021 Partial words (byte_cnt != 0) SHALL be held indefinitely while valid_in=0; there SHALL be no timeout.

Reset
REQ-022 When rst=1 at a clock edge, the block SHALL clear byte_cnt, the assembly register, FIFO pointers and occupancy, word_valid, word_data and overflow to 0.
REQ-023 rst SHALL take priority over valid_in and word_ready in the same cycle.
REQ-024 A partial word in progress at reset SHALL be discarded.
REQ-025 The first byte after rst deasserts SHALL be treated as byte 0.

Configuration
REQ-026 When BYTE_WORD_PACKER_PARITY_EN is defined, the block SHALL add the port word_parity  output  8, with bit i equal to the even parity of byte lane i of word_data.
REQ-027 When BYTE_WORD_PACKER_PARITY_EN is defined, word_parity SHALL be stored in the FIFO alongside its word and SHALL follow the same timing and reset rules as word_data.
REQ-028 When BYTE_WORD_PACKER_PARITY_EN is not defined, the word_parity port and its storage SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package conv_pkg SHALL hold typedefs byte_t (8 bits) and word_t (64 bits), constant BYTES_PER_WORD=8, and constant BCNT_W=3.
REQ-030 The FIFO SHALL be the sub-module packer_fifo: synchronous, parameterised on width and DEPTH, with push/pop/full/empty and registered outputs.
REQ-031 The assembly logic and byte counter SHALL reside in byte_word_packer.

Verification
REQ-032 The bench SHALL cover: after rst, bytes 0x01..0x08 on 8 consecutive cycles with word_ready=1 and MSB_FIRST=1 -> word_valid one cycle later with word_data=0x0102030405060708.
REQ-033 The bench SHALL cover: the same bytes with MSB_FIRST=0 -> word_data=0x0807060504030201.
REQ-034 The bench SHALL cover: word_ready=0 and 3 full words streamed with DEPTH=2 -> first two words retained, third dropped, overflow=1, byte_cnt=0; then word_ready=1 -> words 1 and 2 popped in order and word_valid=0.
REQ-035 The bench SHALL cover: FIFO full with word_ready pulsed on the same cycle as the 8th byte of a new word -> no overflow, occupancy stays 2, new word appears after the old ones.
REQ-036 The bench SHALL cover: 5 bytes then rst, then 8 bytes 0xA0..0xA7 -> word_data=0xA0A1A2A3A4A5A6A7 with no residue from the earlier bytes.
REQ-037 The bench SHALL cover: with BYTE_WORD_PACKER_PARITY_EN defined, a word of all 0x01 bytes -> word_parity=0xFF; with the macro undefined, the design SHALL build without the word_parity port.
